// File: rtl/dfr_axi_lite_cmd_master.sv
// AXI4-Lite command master: runs queued WRITE / READ / READ_CMP / WAIT_BUSY ops against dfr_core_top.
// Define DFR_CMD_TIMEOUT_EN to enable the per-wait-state abort timer (TIMEOUT_CYCLES).
module dfr_axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int CMD_FIFO_DEPTH     = 16,
    parameter int RSP_FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_data,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_mask,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic                              rsp_err,
    input  logic                              dfr_busy,
    output logic [15:0]                       mismatch_cnt,
    output logic                              idle,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int CPW = $clog2(CMD_FIFO_DEPTH);
    localparam int RPW = $clog2(RSP_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WR_AW_W = 3'd1, S_WR_B = 3'd2, S_RD_AR = 3'd3,
        S_RD_R = 3'd4, S_WAIT_BUSY = 3'd5, S_RSP = 3'd6
    } state_t;
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00, OP_READ = 2'b01, OP_READ_CMP = 2'b10, OP_WAIT_BUSY = 2'b11
    } op_t;

    state_t          state;
    op_t             cmd_op_mem   [CMD_FIFO_DEPTH];
    logic [AW-1:0]   cmd_addr_mem [CMD_FIFO_DEPTH];
    logic [DW-1:0]   cmd_data_mem [CMD_FIFO_DEPTH];
    logic [DW-1:0]   cmd_mask_mem [CMD_FIFO_DEPTH];
    logic [DW:0]     rsp_mem      [RSP_FIFO_DEPTH];
    logic [CPW:0]    cmd_wr_ptr, cmd_rd_ptr;
    logic [RPW:0]    rsp_wr_ptr, rsp_rd_ptr;
    logic            cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic            rsp_empty, rsp_full, rsp_push, rsp_pop;
    op_t             cur_op;
    logic [DW-1:0]   cur_data, cur_mask, res_data;
    logic            res_err, aw_done, w_done, aw_fin, w_fin, busy_q, busy_fall;

    assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
    assign cmd_full  = (cmd_wr_ptr[CPW] != cmd_rd_ptr[CPW]) &&
                       (cmd_wr_ptr[CPW-1:0] == cmd_rd_ptr[CPW-1:0]);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign cmd_pop   = (state == S_IDLE) && !cmd_empty;

    assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
    assign rsp_full  = (rsp_wr_ptr[RPW] != rsp_rd_ptr[RPW]) &&
                       (rsp_wr_ptr[RPW-1:0] == rsp_rd_ptr[RPW-1:0]);
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_ready && !rsp_empty;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign rsp_push  = (state == S_RSP) && (!rsp_full || rsp_ready);
    assign rsp_data  = rsp_valid ? rsp_mem[rsp_rd_ptr[RPW-1:0]][DW-1:0] : '0;
    assign rsp_err   = rsp_valid && rsp_mem[rsp_rd_ptr[RPW-1:0]][DW];

    assign idle      = cmd_empty && (state == S_IDLE);
    assign aw_fin    = aw_done || (M_AXI_AWVALID && M_AXI_AWREADY);
    assign w_fin     = w_done || (M_AXI_WVALID && M_AXI_WREADY);
    assign busy_fall = busy_q && !dfr_busy;

    always_ff @(posedge S_AXI_ACLK) begin
        if (cmd_push) begin
            cmd_op_mem[cmd_wr_ptr[CPW-1:0]]   <= op_t'(cmd_op);
            cmd_addr_mem[cmd_wr_ptr[CPW-1:0]] <= cmd_addr;
            cmd_data_mem[cmd_wr_ptr[CPW-1:0]] <= cmd_data;
            cmd_mask_mem[cmd_wr_ptr[CPW-1:0]] <= cmd_mask;
        end
        if (rsp_push) rsp_mem[rsp_wr_ptr[RPW-1:0]] <= {res_err, res_data};
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + (CPW+1)'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + (CPW+1)'(1);
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + (RPW+1)'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + (RPW+1)'(1);
        end
    end

`ifdef DFR_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_wait, done_now, tmo_abort;

    always_comb begin
        in_wait  = 1'b1;
        done_now = 1'b0;
        case (state)
            S_WR_AW_W:   done_now = aw_fin && w_fin;
            S_WR_B:      done_now = M_AXI_BVALID;
            S_RD_AR:     done_now = M_AXI_ARREADY;
            S_RD_R:      done_now = M_AXI_RVALID;
            S_WAIT_BUSY: done_now = busy_fall;
            default:     in_wait  = 1'b0;
        endcase
        tmo_abort = in_wait && !done_now && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Counter is held at zero outside wait states and on every state change, so it restarts per state.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)                    tmo_cnt <= '0;
        else if (!in_wait || done_now || tmo_abort) tmo_cnt <= '0;
        else                                   tmo_cnt <= tmo_cnt + TW'(1);
    end
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= S_IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            cur_op        <= OP_WRITE;
            cur_data      <= '0;
            cur_mask      <= '0;
            res_data      <= '0;
            res_err       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            busy_q        <= 1'b0;
            mismatch_cnt  <= '0;
        end else begin
            busy_q <= dfr_busy;
            case (state)
                S_IDLE: if (!cmd_empty) begin
                    cur_op   <= cmd_op_mem[cmd_rd_ptr[CPW-1:0]];
                    cur_data <= cmd_data_mem[cmd_rd_ptr[CPW-1:0]];
                    cur_mask <= cmd_mask_mem[cmd_rd_ptr[CPW-1:0]];
                    res_data <= '0;
                    res_err  <= 1'b0;
                    case (cmd_op_mem[cmd_rd_ptr[CPW-1:0]])
                        OP_WRITE: begin
                            M_AXI_AWADDR  <= cmd_addr_mem[cmd_rd_ptr[CPW-1:0]];
                            M_AXI_WDATA   <= cmd_data_mem[cmd_rd_ptr[CPW-1:0]];
                            M_AXI_WSTRB   <= '1;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= S_WR_AW_W;
                        end
                        OP_READ, OP_READ_CMP: begin
                            M_AXI_ARADDR  <= cmd_addr_mem[cmd_rd_ptr[CPW-1:0]];
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_AR;
                        end
                        default: state <= S_WAIT_BUSY;
                    endcase
                end
                S_WR_AW_W: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (M_AXI_WVALID && M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WR_B;
                    end
                end
                S_WR_B: if (M_AXI_BVALID) begin
                    M_AXI_BREADY <= 1'b0;
                    res_err      <= |M_AXI_BRESP;
                    state        <= S_RSP;
                end
                S_RD_AR: if (M_AXI_ARREADY) begin
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b1;
                    state         <= S_RD_R;
                end
                S_RD_R: if (M_AXI_RVALID) begin
                    M_AXI_RREADY <= 1'b0;
                    res_data     <= M_AXI_RDATA;
                    res_err      <= (|M_AXI_RRESP) || ((cur_op == OP_READ_CMP) &&
                                    ((M_AXI_RDATA | cur_mask) != (cur_data | cur_mask)));
                    state        <= S_RSP;
                end
                S_WAIT_BUSY: if (busy_fall) state <= S_RSP;
                S_RSP: if (rsp_push) begin
                    if (res_err && mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`ifdef DFR_CMD_TIMEOUT_EN
            if (tmo_abort) begin
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                res_err       <= 1'b1;
                res_data      <= DW'({16'hDEAD, 13'd0, state});
                state         <= S_RSP;
            end
`endif
        end
    end
endmodule
